// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: word size, bubble encoding,
// FSM state type and the IF/ID pipeline bundle.
package instr_fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Hazard/redirect inputs, memory address/data and IF/ID outputs of the fetch
// stage; master is the pipeline environment, slave is the fetch stage.
interface instr_fetch_stage_if #(
  parameter int CNT_W = 16
);
  import instr_fetch_stage_pkg::*;

  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              pc_src_e;
  logic [XLEN-1:0]   pc_target_e;
  logic [XLEN-1:0]   instr_f;
  logic [XLEN-1:0]   pc_f;
  logic [XLEN-1:0]   instr_d;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   pc_plus4_d;
  logic              valid_d;
  logic              misalign_o;
  logic [CNT_W-1:0]  fetch_count;
  logic [CNT_W-1:0]  redirect_count;
  fsm_state_t        state;

  // All signals are level-sampled at posedge clk; there is no valid/ready
  // handshake, the hazard unit controls flow purely through stall/flush.
  modport master (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, instr_f,
    input  pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_o,
           fetch_count, redirect_count, state
  );

  modport slave (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, instr_f,
    output pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misalign_o,
           fetch_count, redirect_count, state
  );

endinterface

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble and wins over stall.
module if_id_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output if_id_t          if_id
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id <= '{instr: BUBBLE, pc: '0, pc_plus4: '0, valid: 1'b0};
    end else if (flush) begin
      // A bubble still records the PC it displaced, which helps trace debug.
      if_id <= '{instr: BUBBLE, pc: pc_in, pc_plus4: pc_in + XLEN'(4), valid: 1'b0};
    end else if (!stall) begin
      if_id <= '{instr: instr_in, pc: pc_in, pc_plus4: pc_in + XLEN'(4), valid: 1'b1};
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC register, BOOT/RUN sequencing, branch redirect and debug
// counters; the IF/ID register itself lives in if_id_reg.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = instr_fetch_stage_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_fetch_stage_if.slave     bus
);
  import instr_fetch_stage_pkg::*;

  fsm_state_t       state;
  logic [XLEN-1:0]  pc;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] redirect_cnt;
  if_id_t           if_id;
  logic             boot;

  assign boot = (state == BOOT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      misalign     <= 1'b0;
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      misalign <= 1'b0;
      if (state == BOOT) begin
        state <= RUN;
      end else begin
        // Redirect beats stall_f: the wrong-path fetch must be abandoned.
        if (bus.pc_src_e) begin
          pc           <= {bus.pc_target_e[XLEN-1:2], 2'b00};
          misalign     <= |bus.pc_target_e[1:0];
          redirect_cnt <= redirect_cnt + CNT_W'(1);
        end else if (!bus.stall_f) begin
          pc <= pc + XLEN'(4);
        end
        if (!bus.flush_d && !bus.stall_d) begin
          fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
      end
    end
  end

  // BOOT behaves as a forced flush so ID starts from a bubble.
  if_id_reg #(
    .BUBBLE (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (boot | bus.flush_d),
    .stall    (bus.stall_d),
    .instr_in (bus.instr_f),
    .pc_in    (pc),
    .if_id    (if_id)
  );

  assign bus.pc_f           = pc;
  assign bus.instr_d        = if_id.instr;
  assign bus.pc_d           = if_id.pc;
  assign bus.pc_plus4_d     = if_id.pc_plus4;
  assign bus.valid_d        = if_id.valid;
  assign bus.misalign_o     = misalign;
  assign bus.fetch_count    = fetch_cnt;
  assign bus.redirect_count = redirect_cnt;
  assign bus.state          = state;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline; sits directly upstream of the combinational instruction memory.
- Owns the PC register and drives the memory word address.
- Captures the returned instruction into the IF/ID pipeline register together with PC and PC+4.
- Applies hazard-unit stall/flush and execute-stage branch redirects; keeps fetch/redirect counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) inserted into ID.
- CNT_W, 16, width of the debug counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall_f  in  1  hold PC
- stall_d  in  1  hold IF/ID register
- flush_d  in  1  replace IF/ID contents with bubble
- pc_src_e  in  1  taken branch/jump resolved in EX
- pc_target_e  in  32  redirect target from EX
- instr_f  in  32  instruction word from instruction memory (RD)
- pc_f  out  32  fetch address to instruction memory (A)
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- misalign_o  out  1  one-cycle pulse: redirect target had bits [1:0] != 0
- fetch_count  out  CNT_W  valid instructions delivered to ID
- redirect_count  out  CNT_W  redirects taken

Behaviour:
- Everything is evaluated on posedge clk only; rst_n is synchronous.
- Reset (rst_n=0) values:
  - pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0
  - misalign_o=0, both counters=0, state=BOOT
- A reset asserted mid-operation overrides all other inputs in that cycle.
- FSM, two states:
  - BOOT: exactly one cycle after rst_n rises. pc_f holds RESET_PC, IF/ID loads the bubble, redirect and stall inputs are ignored, counters are frozen. Next state is RUN.
  - RUN: normal operation; remains in RUN until reset.
- PC update in RUN, in priority order:
  1. pc_src_e=1: pc_f <= {pc_target_e[31:2],2'b00}. A redirect overrides stall_f. misalign_o pulses for 1 cycle if pc_target_e[1:0]!=0. redirect_count += 1.
  2. else stall_f=1: pc_f holds.
  3. else: pc_f <= pc_f+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- IF/ID update in RUN, in priority order:
  1. flush_d=1: instr_d=NOP_INSTR, valid_d=0. pc_d and pc_plus4_d take the current pc_f and pc_f+4. Flush overrides stall_d.
  2. else stall_d=1: all IF/ID outputs hold.
  3. else: instr_d=instr_f, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1, fetch_count += 1.
- Latency: an instruction appears on instr_d one cycle after its address is on pc_f.
- Memory is combinational, so instr_f is sampled in the same cycle pc_f is driven.
- Counters wrap modulo 2^CNT_W.
- pc_src_e together with flush_d (the normal taken-branch case): PC is redirected and ID is bubbled in the same edge.
- stall_f=1 with stall_d=0 is legal: ID reloads the same pc_f; no special handling.

Decomposition:
- Shared pipeline package holds:
  - XLEN=32
  - NOP_INSTR constant
  - the fsm state enum (BOOT, RUN)
  - the IF/ID bundle typedef (instr, pc, pc_plus4, valid)
- One natural sub-module: if_id_reg, holding the IF/ID register with flush/stall priority. The PC, FSM and counters stay in the top.

Test Plan:
- Reset release, no stalls, memory word i = 32'h1000_0000+i: pc_f 0 (BOOT), then 0,4,8... instr_d shows bubble, then 32'h1000_0000 at the cycle after the first RUN fetch; fetch_count=3 after 3 RUN cycles.
- In RUN at pc_f=0x0C, assert pc_src_e=1, pc_target_e=0x34, flush_d=1: next pc_f=0x34, instr_d=0x00000013, valid_d=0, redirect_count=1; the following cycle instr_d=mem[13].
- stall_f=1 and stall_d=1 for 3 cycles at pc_f=0x10: pc_f stays 0x10, IF/ID unchanged, fetch_count unchanged; after release pc_f=0x14.
- pc_src_e=1 with stall_f=1, pc_target_e=0x22: pc_f=0x20, misalign_o high for exactly 1 cycle.
- Assert rst_n=0 mid-run at pc_f=0x28 with pc_src_e=1: next edge gives pc_f=RESET_PC, valid_d=0, counters=0, state=BOOT.
- Force pc_f to 32'hFFFF_FFFC (RESET_PC override): the next RUN fetch gives pc_f=0, and pc_plus4_d=0 for that instruction.
